tetris_input_sequencer: RTL and testbench

// - Sits upstream of tetris_control. Converts the raw USB keycode (Nios PIO keycode[7:0]) and the

---
 rtl/tetris_input_sequencer_if.sv | 15 +
 rtl/tetris_input_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_tetris_input_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_input_sequencer_if.sv
// Command handshake between tetris_input_sequencer (master) and
// tetris_control (slave).
//   cmd_valid   : slot holds a command
//   cmd_ready   : consumer accepts the command this cycle
//   cmd[2:0]    : 0 LEFT, 1 RIGHT, 2 ROTATE, 3 DOWN, 4 DROP, 5 HOLD
//   cmd_gravity : DOWN command originated from the gravity timer
interface tetris_input_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic       cmd_gravity;

  modport master (output cmd_valid, output cmd, output cmd_gravity, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, input cmd_gravity, output cmd_ready);
endinterface

// File: rtl/tetris_input_sequencer.sv
// tetris_input_sequencer
// Turns the raw USB keycode and the VGA frame strobe into single move
// commands for tetris_control: press detection, DAS/ARR auto-repeat,
// level-scaled gravity and fixed-priority arbitration into a one-entry slot.
// Optional feature: define TETRIS_HOLD_EN to add the HOLD key (cmd=5).
// Ports:
//   clk         : system clock
//   reset       : asynchronous, active-high
//   game_active : low flushes and holds all state
//   keycode     : current USB keycode, 8'h00 = no key
//   frame_vs    : VGA_VS, active low, synchronous to clk
//   level       : current level 0..15
//   frame_tick  : one-cycle pulse on the falling edge of frame_vs
//   cmd_if      : command handshake (master side)
module tetris_input_sequencer #(
  parameter logic [7:0]  KEY_LEFT   = 8'h04,
  parameter logic [7:0]  KEY_RIGHT  = 8'h07,
  parameter logic [7:0]  KEY_ROT    = 8'h1A,
  parameter logic [7:0]  KEY_DOWN   = 8'h16,
  parameter logic [7:0]  KEY_DROP   = 8'h2C,
`ifdef TETRIS_HOLD_EN
  parameter logic [7:0]  KEY_HOLD   = 8'h06,
`endif
  parameter int unsigned DAS_FRAMES = 12,
  parameter int unsigned ARR_FRAMES = 3,
  parameter int unsigned GRAV_BASE  = 48,
  parameter int unsigned GRAV_STEP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_active,
  input  logic [7:0] keycode,
  input  logic       frame_vs,
  input  logic [3:0] level,
  output logic       frame_tick,
  tetris_input_sequencer_if.master cmd_if
);

  typedef enum logic {S_EMPTY, S_FULL} state_e;
  typedef enum logic [2:0] {
    CMD_LEFT = 3'd0, CMD_RIGHT = 3'd1, CMD_ROT = 3'd2,
    CMD_DOWN = 3'd3, CMD_DROP  = 3'd4, CMD_HOLD = 3'd5
  } cmd_e;

  // Pending-flag bit positions
  localparam int unsigned EV_LEFT  = 0;
  localparam int unsigned EV_RIGHT = 1;
  localparam int unsigned EV_ROT   = 2;
  localparam int unsigned EV_DOWN  = 3;
  localparam int unsigned EV_DROP  = 4;
  localparam int unsigned EV_HOLD  = 5;
  localparam int unsigned EV_GRAV  = 6;
  localparam int unsigned NEV      = 7;

  logic           vs_q;
  logic [7:0]     key_q, key_prev_q;
  logic [4:0]     hold_q, hold_d, hold_inc;
  logic           rep_en_q, rep_en_d;
  logic [7:0]     grav_cnt_q, grav_cnt_d;
  logic [NEV-1:0] flag_q, flag_d;
  state_e         state_q, state_d;
  cmd_e           cmd_q, cmd_d;
  logic           grav_q, grav_d;

  logic [NEV-1:0] key_oh, ev, pend, win_sel;
  logic           key_changed, press, rep_fire, grav_ev, key_down_acc, load;
  logic [7:0]     grav_sub, interval;
  cmd_e           win_cmd;
  logic           win_grav;

  assign frame_tick = vs_q & ~frame_vs;

  always_comb begin
    key_oh = '0;
    if      (key_q == KEY_LEFT)  key_oh[EV_LEFT]  = 1'b1;
    else if (key_q == KEY_RIGHT) key_oh[EV_RIGHT] = 1'b1;
    else if (key_q == KEY_ROT)   key_oh[EV_ROT]   = 1'b1;
    else if (key_q == KEY_DOWN)  key_oh[EV_DOWN]  = 1'b1;
    else if (key_q == KEY_DROP)  key_oh[EV_DROP]  = 1'b1;
`ifdef TETRIS_HOLD_EN
    else if (key_q == KEY_HOLD)  key_oh[EV_HOLD]  = 1'b1;
`endif
  end

  assign key_changed  = (key_q != key_prev_q);
  assign press        = key_changed & (|key_oh);
  assign key_down_acc = cmd_if.cmd_valid & cmd_if.cmd_ready & (cmd_q == CMD_DOWN) & ~grav_q;

  // Hold counter: DAS fires at DAS_FRAMES, then the counter folds back to
  // DAS_FRAMES every ARR_FRAMES so it stays bounded while a key is held.
  always_comb begin
    hold_inc = hold_q + 5'd1;
    hold_d   = hold_q;
    rep_fire = 1'b0;
    if (!game_active || key_changed) begin
      hold_d = '0;
    end else if (frame_tick) begin
      hold_d = (hold_inc == 5'(DAS_FRAMES + ARR_FRAMES)) ? 5'(DAS_FRAMES) : hold_inc;
      rep_fire = (hold_inc == 5'(DAS_FRAMES)) || (hold_inc == 5'(DAS_FRAMES + ARR_FRAMES));
    end
  end

  // Repeat is armed only by a press seen while the game runs, so a key held
  // across a flush never auto-repeats until it is pressed again.
  always_comb begin
    rep_en_d = rep_en_q;
    if (!game_active)     rep_en_d = 1'b0;
    else if (key_changed) rep_en_d = press;
  end

  always_comb begin
    grav_sub = 8'(GRAV_STEP) * {4'd0, level};
    interval = (8'(GRAV_BASE) > grav_sub) ? (8'(GRAV_BASE) - grav_sub) : 8'd1;
    grav_cnt_d = grav_cnt_q;
    grav_ev    = 1'b0;
    if (!game_active || key_down_acc) begin
      grav_cnt_d = '0;
    end else if (frame_tick) begin
      // >= so a level raised mid-count fires promptly instead of wrapping
      if (grav_cnt_q >= interval - 8'd1) begin
        grav_cnt_d = '0;
        grav_ev    = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + 8'd1;
      end
    end
  end

  // New events bypass the flags so a press reaches the slot two edges after
  // the keycode changes.
  always_comb begin
    ev = '0;
    if (game_active) begin
      if (press) ev = key_oh;
      if (rep_fire && rep_en_q && !key_changed)
        ev = ev | (key_oh & 7'b0001011);
      ev[EV_GRAV] = grav_ev;
    end
    pend = flag_q | ev;
    if (key_down_acc) pend[EV_GRAV] = 1'b0;
  end

  always_comb begin
    win_sel  = '0;
    win_cmd  = CMD_LEFT;
    win_grav = 1'b0;
    if (pend[EV_DROP]) begin
      win_sel[EV_DROP] = 1'b1; win_cmd = CMD_DROP;
    end else if (pend[EV_HOLD]) begin
      win_sel[EV_HOLD] = 1'b1; win_cmd = CMD_HOLD;
    end else if (pend[EV_ROT]) begin
      win_sel[EV_ROT] = 1'b1; win_cmd = CMD_ROT;
    end else if (pend[EV_LEFT]) begin
      win_sel[EV_LEFT] = 1'b1; win_cmd = CMD_LEFT;
    end else if (pend[EV_RIGHT]) begin
      win_sel[EV_RIGHT] = 1'b1; win_cmd = CMD_RIGHT;
    end else if (pend[EV_DOWN]) begin
      win_sel[EV_DOWN] = 1'b1; win_cmd = CMD_DOWN;
    end else if (pend[EV_GRAV]) begin
      win_sel[EV_GRAV] = 1'b1; win_cmd = CMD_DOWN; win_grav = 1'b1;
    end
  end

  assign load = game_active & (|pend) & ((state_q == S_EMPTY) | cmd_if.cmd_ready);

  // A loaded flag that sees a fresh event of its own type in the same cycle
  // stays set: one event in the slot, one still pending.
  always_comb begin
    flag_d = '0;
    if (game_active) begin
      for (int unsigned i = 0; i < NEV; i++)
        flag_d[i] = (load && win_sel[i]) ? (flag_q[i] & ev[i]) : (flag_q[i] | ev[i]);
      if (key_down_acc) flag_d[EV_GRAV] = 1'b0;
    end
  end

  always_comb begin
    cmd_d  = cmd_q;
    grav_d = grav_q;
    if (load) begin
      cmd_d  = win_cmd;
      grav_d = win_grav;
    end
  end

  // Slot FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Slot FSM: next state
  always_comb begin
    state_d = state_q;
    if (!game_active) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (|pend) state_d = S_FULL;
        S_FULL:  if (cmd_if.cmd_ready && !(|pend)) state_d = S_EMPTY;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Slot FSM: outputs
  always_comb begin
    cmd_if.cmd_valid   = (state_q == S_FULL);
    cmd_if.cmd         = cmd_q;
    cmd_if.cmd_gravity = grav_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q       <= 1'b0;
      key_q      <= '0;
      key_prev_q <= '0;
      hold_q     <= '0;
      rep_en_q   <= 1'b0;
      grav_cnt_q <= '0;
      flag_q     <= '0;
      cmd_q      <= CMD_LEFT;
      grav_q     <= 1'b0;
    end else begin
      vs_q       <= frame_vs;
      key_q      <= keycode;
      key_prev_q <= key_q;
      hold_q     <= hold_d;
      rep_en_q   <= rep_en_d;
      grav_cnt_q <= grav_cnt_d;
      flag_q     <= flag_d;
      cmd_q      <= cmd_d;
      grav_q     <= grav_d;
    end
  end

endmodule

// File: tb/tb_tetris_input_sequencer.sv
module tb_tetris_input_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       game_active;
  logic [7:0] keycode;
  logic       frame_vs;
  logic [3:0] level;
  logic       frame_tick;

  tetris_input_sequencer_if cmd_if ();

  tetris_input_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .game_active (game_active),
    .keycode     (keycode),
    .frame_vs    (frame_vs),
    .level       (level),
    .frame_tick  (frame_tick),
    .cmd_if      (cmd_if)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int acc_cnt [8];
  int gcnt, kdown, acc_all;
  logic [2:0] last_cmd;
  logic       last_grav;

  // Accepted-command log, sampled mid-cycle before the accepting edge.
  always @(negedge clk) begin
    if (!reset && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      acc_cnt[cmd_if.cmd] = acc_cnt[cmd_if.cmd] + 1;
      acc_all = acc_all + 1;
      if (cmd_if.cmd_gravity) gcnt = gcnt + 1;
      else if (cmd_if.cmd == 3'd3) kdown = kdown + 1;
      last_cmd  = cmd_if.cmd;
      last_grav = cmd_if.cmd_gravity;
    end
  end

  task automatic clear_log();
    for (int i = 0; i < 8; i++) acc_cnt[i] = 0;
    gcnt = 0; kdown = 0; acc_all = 0;
    last_cmd = 3'd7; last_grav = 1'bx;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_vs = 1'b0;
      cyc(2);
      frame_vs = 1'b1;
      cyc(3);
    end
  endtask

  task automatic flush();
    game_active = 1'b0;
    cyc(2);
    game_active = 1'b1;
    clear_log();
    cyc(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_log();
    reset = 1'b1; game_active = 1'b0; keycode = 8'h00; frame_vs = 1'b1;
    level = 4'd0; cmd_if.cmd_ready = 1'b0;
    cyc(3);
    chk("rst_valid", cmd_if.cmd_valid, 0);
    chk("rst_cmd", cmd_if.cmd, 0);
    chk("rst_grav", cmd_if.cmd_gravity, 0);
    chk("rst_tick", frame_tick, 0);

    // Press and repeat
    reset = 1'b0; game_active = 1'b1; cmd_if.cmd_ready = 1'b1;
    cyc(3);
    clear_log();
    keycode = 8'h04;
    cyc(1);
    chk("lat_n1_valid", cmd_if.cmd_valid, 0);
    cyc(1);
    chk("lat_n2_valid", cmd_if.cmd_valid, 1);
    chk("lat_n2_cmd", cmd_if.cmd, 0);
    cyc(2);
    frames(11);
    chk("left_f11", acc_cnt[0], 1);
    frames(1);
    chk("left_f12", acc_cnt[0], 2);
    frames(13);
    chk("left_f25", acc_cnt[0], 6);
    keycode = 8'h00;
    frames(2);
    chk("left_release", acc_cnt[0], 6);
    chk("left_only", acc_all, 6);

    // Rotate and release
    flush();
    keycode = 8'h1A;
    frames(40);
    keycode = 8'h00;
    frames(2);
    chk("rot_once", acc_cnt[2], 1);
    chk("rot_only", acc_all, 1);

    // Gravity level 0
    flush();
    level = 4'd0;
    frames(47);
    chk("grav0_f47", gcnt, 0);
    frames(1);
    chk("grav0_f48", gcnt, 1);
    chk("grav0_cmd", last_cmd, 3);
    chk("grav0_flag", last_grav, 1);
    frames(48);
    chk("grav0_f96", gcnt, 2);

    // Accepted key DOWN restarts gravity
    level = 4'd11;
    flush();
    frames(3);
    keycode = 8'h16;
    cyc(4);
    chk("kdown_acc", kdown, 1);
    frames(3);
    chk("kdown_grav_f3", gcnt, 0);
    frames(1);
    chk("kdown_grav_f4", gcnt, 1);
    keycode = 8'h00;
    cyc(2);

    // Gravity level 11 and 15
    flush();
    frames(3);
    chk("grav11_f3", gcnt, 0);
    frames(1);
    chk("grav11_f4", gcnt, 1);
    frames(4);
    chk("grav11_f8", gcnt, 2);
    level = 4'd15;
    flush();
    frames(5);
    chk("grav15_f5", gcnt, 5);
    level = 4'd0;
    flush();

    // Stall and priority
    cmd_if.cmd_ready = 1'b0;
    keycode = 8'h2C;
    cyc(3);
    chk("stall_valid", cmd_if.cmd_valid, 1);
    chk("stall_drop", cmd_if.cmd, 4);
    keycode = 8'h07;
    cyc(3);
    chk("stall_hold_valid", cmd_if.cmd_valid, 1);
    chk("stall_hold_cmd", cmd_if.cmd, 4);
    cmd_if.cmd_ready = 1'b1;
    cyc(1);
    chk("b2b_valid", cmd_if.cmd_valid, 1);
    chk("b2b_right", cmd_if.cmd, 1);
    cyc(1);
    chk("b2b_empty", cmd_if.cmd_valid, 0);
    chk("b2b_drop_cnt", acc_cnt[4], 1);
    chk("b2b_right_cnt", acc_cnt[1], 1);

    // Flush and resume
    keycode = 8'h00;
    cyc(2);
    cmd_if.cmd_ready = 1'b0;
    keycode = 8'h07;
    cyc(3);
    chk("flush_pre_valid", cmd_if.cmd_valid, 1);
    game_active = 1'b0;
    cyc(1);
    chk("flush_valid", cmd_if.cmd_valid, 0);
    cyc(3);
    game_active = 1'b1;
    cmd_if.cmd_ready = 1'b1;
    clear_log();
    frames(3);
    chk("resume_no_right", acc_cnt[1], 0);
    chk("resume_idle", cmd_if.cmd_valid, 0);
    keycode = 8'h00;
    cyc(2);
    keycode = 8'h07;
    cyc(4);
    chk("repress_right", acc_cnt[1], 1);

    // Reset mid-operation
    cmd_if.cmd_ready = 1'b0;
    keycode = 8'h2C;
    cyc(3);
    chk("prerst_valid", cmd_if.cmd_valid, 1);
    #5;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", cmd_if.cmd_valid, 0);
    chk("async_rst_cmd", cmd_if.cmd, 0);
    chk("async_rst_grav", cmd_if.cmd_gravity, 0);
    keycode = 8'h00;
    cyc(2);
    reset = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    clear_log();
    cyc(5);
    chk("postrst_valid", cmd_if.cmd_valid, 0);
    chk("postrst_none", acc_all, 0);

    // HOLD key (unknown when the feature is not built)
    keycode = 8'h06;
    cyc(4);
`ifdef TETRIS_HOLD_EN
    chk("hold_once", acc_cnt[5], 1);
    frames(14);
    chk("hold_no_repeat", acc_cnt[5], 1);
`else
    chk("hold_unknown", acc_all, 0);
    frames(14);
    chk("hold_unknown_held", acc_all, 0);
`endif
    keycode = 8'h00;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
